// File: rtl/sync_1101_framer.sv
// Serialises parallel words into frames of sync pattern 1101 followed by the payload, MSB first.
// Define SYNC_1101_FRAMER_PARITY_EN to append an even-parity bit to every frame.
module sync_1101_framer #(
   parameter int   DATA_W   = 8,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              x,
   output logic              x_valid,
   output logic              frame_done
);

   localparam int              CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] DATA_ONE  = CNT_W'(1);
   localparam logic [3:0]       SYNC_PAT  = 4'b1101;

`ifdef SYNC_1101_FRAMER_PARITY_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SYNC = 2'd1, ST_DATA = 2'd2, ST_PAR = 2'd3} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SYNC = 2'd1, ST_DATA = 2'd2} state_t;
`endif

   state_t            state_r, state_s;
   logic [1:0]        sync_cnt_r, sync_cnt_s;
   logic [CNT_W-1:0]  data_cnt_r, data_cnt_s;
   logic [DATA_W-1:0] shift_r, shift_s;
   logic              x_r, x_s;
   logic              x_valid_r, x_valid_s;
   logic              frame_done_r, frame_done_s;
   logic              final_bit_s;
   logic              transfer_s;
`ifdef SYNC_1101_FRAMER_PARITY_EN
   logic              par_r, par_s;

   function automatic logic even_parity(input logic [DATA_W-1:0] word);
      return ^word;
   endfunction
`endif

   // Final-bit decode: the only cycles besides IDLE in which a new word may be taken
   always_comb begin
      final_bit_s = 1'b0;
`ifdef SYNC_1101_FRAMER_PARITY_EN
      if (state_r == ST_PAR) begin
         final_bit_s = 1'b1;
      end else begin
         final_bit_s = 1'b0;
      end
`else
      if ((state_r == ST_DATA) && (data_cnt_r == DATA_LAST)) begin
         final_bit_s = 1'b1;
      end else begin
         final_bit_s = 1'b0;
      end
`endif
   end

   assign data_ready = (state_r == ST_IDLE) || final_bit_s;
   assign transfer_s = data_valid && data_ready;

   // Next-state, counter and shift-register update
   always_comb begin
      state_s    = state_r;
      sync_cnt_s = sync_cnt_r;
      data_cnt_s = data_cnt_r;
      shift_s    = shift_r;
`ifdef SYNC_1101_FRAMER_PARITY_EN
      par_s      = par_r;
`endif
      case (state_r)
         ST_IDLE: begin
            state_s = transfer_s ? ST_SYNC : ST_IDLE;
         end
         ST_SYNC: begin
            if (sync_cnt_r == 2'd3) begin
               state_s    = ST_DATA;
               data_cnt_s = {CNT_W{1'b0}};
            end else begin
               sync_cnt_s = sync_cnt_r + 2'd1;
            end
         end
         ST_DATA: begin
            if (data_cnt_r == DATA_LAST) begin
`ifdef SYNC_1101_FRAMER_PARITY_EN
               state_s = ST_PAR;
`else
               state_s = transfer_s ? ST_SYNC : ST_IDLE;
`endif
            end else begin
               data_cnt_s = data_cnt_r + DATA_ONE;
               shift_s    = {shift_r[DATA_W-2:0], 1'b0};
            end
         end
`ifdef SYNC_1101_FRAMER_PARITY_EN
         ST_PAR: begin
            state_s = transfer_s ? ST_SYNC : ST_IDLE;
         end
`endif
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      // A transfer can only happen in IDLE or on the final bit, so it never disturbs a frame
      if (transfer_s) begin
         sync_cnt_s = 2'd0;
         shift_s    = data_in;
`ifdef SYNC_1101_FRAMER_PARITY_EN
         par_s      = even_parity(data_in);
`endif
      end else begin
         sync_cnt_s = sync_cnt_s;
      end
   end

   // Outputs are decoded from the next state so the registered x lines up with it
   always_comb begin
      x_s          = IDLE_BIT;
      x_valid_s    = 1'b0;
      frame_done_s = 1'b0;
      case (state_s)
         ST_IDLE: begin
            x_s       = IDLE_BIT;
            x_valid_s = 1'b0;
         end
         ST_SYNC: begin
            x_s       = SYNC_PAT[2'd3 - sync_cnt_s];
            x_valid_s = 1'b1;
         end
         ST_DATA: begin
            x_s       = shift_s[DATA_W-1];
            x_valid_s = 1'b1;
`ifdef SYNC_1101_FRAMER_PARITY_EN
            frame_done_s = 1'b0;
`else
            frame_done_s = (data_cnt_s == DATA_LAST);
`endif
         end
`ifdef SYNC_1101_FRAMER_PARITY_EN
         ST_PAR: begin
            x_s          = par_s;
            x_valid_s    = 1'b1;
            frame_done_s = 1'b1;
         end
`endif
         default: begin
            x_s       = IDLE_BIT;
            x_valid_s = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         sync_cnt_r   <= 2'd0;
         data_cnt_r   <= {CNT_W{1'b0}};
         shift_r      <= {DATA_W{1'b0}};
         x_r          <= IDLE_BIT;
         x_valid_r    <= 1'b0;
         frame_done_r <= 1'b0;
`ifdef SYNC_1101_FRAMER_PARITY_EN
         par_r        <= 1'b0;
`endif
      end else begin
         state_r      <= state_s;
         sync_cnt_r   <= sync_cnt_s;
         data_cnt_r   <= data_cnt_s;
         shift_r      <= shift_s;
         x_r          <= x_s;
         x_valid_r    <= x_valid_s;
         frame_done_r <= frame_done_s;
`ifdef SYNC_1101_FRAMER_PARITY_EN
         par_r        <= par_s;
`endif
      end
   end

   assign x          = x_r;
   assign x_valid    = x_valid_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_sync_1101_framer.sv
// Self-checking bench for sync_1101_framer (DATA_W=8, IDLE_BIT=0); follows
// SYNC_1101_FRAMER_PARITY_EN when it is defined for the build.
module tb_sync_1101_framer;

   localparam int DW = 8;
`ifdef SYNC_1101_FRAMER_PARITY_EN
   localparam int FL = 13;
`else
   localparam int FL = 12;
`endif

   logic          clk;
   logic          reset_n;
   logic [DW-1:0] data_in;
   logic          data_valid;
   logic          data_ready;
   logic          x;
   logic          x_valid;
   logic          frame_done;

   int checks = 0;
   int errors = 0;

   // Reference model: the bit on x now plus the queue of bits still to send
   logic m_x, m_xv, m_fd;
   logic m_q[$];

   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      logic          ex;
      logic          exv;
      logic          efd;
      logic          erdy;
   } vec_t;

   vec_t tbl[FL+2];

   sync_1101_framer #(.DATA_W(DW), .IDLE_BIT(1'b0)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .x          (x),
      .x_valid    (x_valid),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [FL-1:0] exp_bits(input logic [DW-1:0] d);
`ifdef SYNC_1101_FRAMER_PARITY_EN
      return {4'b1101, d, ^d};
`else
      return {4'b1101, d};
`endif
   endfunction

   task automatic model_reset();
      m_x  = 1'b0;
      m_xv = 1'b0;
      m_fd = 1'b0;
      m_q.delete();
   endtask

   task automatic model_edge(input logic v, input logic [DW-1:0] d);
      logic          rdy;
      logic [FL-1:0] f;
      rdy = !m_xv || m_fd;
      if (m_q.size() == 0 && v && rdy) begin
         f = exp_bits(d);
         for (int i = FL - 1; i >= 0; i--) m_q.push_back(f[i]);
      end
      if (m_q.size() != 0) begin
         m_x  = m_q.pop_front();
         m_xv = 1'b1;
         m_fd = (m_q.size() == 0);
      end else begin
         m_x  = 1'b0;
         m_xv = 1'b0;
         m_fd = 1'b0;
      end
   endtask

   // One clock: drive inputs, advance the model on the edge, compare #1 later
   task automatic cyc(input logic v, input logic [DW-1:0] d);
      data_valid = v;
      data_in    = d;
      @(posedge clk);
      model_edge(v, d);
      #1;
      chk("model_x", x, m_x);
      chk("model_x_valid", x_valid, m_xv);
      chk("model_frame_done", frame_done, m_fd);
      chk("model_data_ready", data_ready, !m_xv || m_fd);
   endtask

   task automatic run_frame(input logic [DW-1:0] d, output logic [FL-1:0] bits);
      for (int i = 0; i < FL; i++) begin
         cyc(i == 0, d);
         bits[FL-1-i] = x;
      end
   endtask

   initial begin
      logic [FL-1:0] bits;
      logic [FL-1:0] a5_bits;
      logic [FL-1:0] c3_bits;
      logic [DW-1:0] payload;
      logic [2:0]    hist;
      logic          y;
      int            ycount;

      reset_n    = 1'b1;
      data_valid = 1'b0;
      data_in    = 8'h00;
      #1 reset_n = 1'b0;
      #2;
      model_reset();
      chk("reset_x", x, 1'b0);
      chk("reset_x_valid", x_valid, 1'b0);
      chk("reset_frame_done", frame_done, 1'b0);
      chk("reset_data_ready", data_ready, 1'b1);
      @(negedge clk);
      reset_n = 1'b1;

      // Single 0xA5 frame from a fixed table
`ifdef SYNC_1101_FRAMER_PARITY_EN
      a5_bits = {12'b1101_1010_0101, 1'b0};
      c3_bits = {12'b1101_0011_1100, 1'b0};
`else
      a5_bits = 12'b1101_1010_0101;
      c3_bits = 12'b1101_0011_1100;
`endif
      for (int i = 0; i < FL + 2; i++) begin
         tbl[i].v = (i == 0);
         tbl[i].d = 8'hA5;
         if (i < FL) begin
            tbl[i].ex   = a5_bits[FL-1-i];
            tbl[i].exv  = 1'b1;
            tbl[i].efd  = (i == FL - 1);
            tbl[i].erdy = (i == FL - 1);
         end else begin
            tbl[i].ex   = 1'b0;
            tbl[i].exv  = 1'b0;
            tbl[i].efd  = 1'b0;
            tbl[i].erdy = 1'b1;
         end
      end
      for (int i = 0; i < FL + 2; i++) begin
         cyc(tbl[i].v, tbl[i].d);
         chk("tbl_x", x, tbl[i].ex);
         chk("tbl_x_valid", x_valid, tbl[i].exv);
         chk("tbl_frame_done", frame_done, tbl[i].efd);
         chk("tbl_data_ready", data_ready, tbl[i].erdy);
      end

`ifdef SYNC_1101_FRAMER_PARITY_EN
      run_frame(8'hA5, bits);
      chk("parity_a5", bits[0], 1'b0);
      cyc(1'b0, 8'h00);
      run_frame(8'h01, bits);
      chk("parity_01", bits[0], 1'b1);
      cyc(1'b0, 8'h00);
`endif

      // Back-to-back 0x0F, 0xF0 with data_valid held high
      for (int n = 0; n < 2 * FL; n++) begin
         cyc(1'b1, (n == 0) ? 8'h0F : 8'hF0);
         chk("b2b_x_valid", x_valid, 1'b1);
         chk("b2b_data_ready", data_ready, (n + 1 == FL) || (n + 1 == 2 * FL));
         chk("b2b_frame_done", frame_done, (n + 1 == FL) || (n + 1 == 2 * FL));
      end
      cyc(1'b0, 8'h00);
      chk("b2b_end_x_valid", x_valid, 1'b0);

      // 0xFF offered while busy must be ignored
      payload = 8'h00;
      for (int n = 0; n < FL; n++) begin
         cyc((n == 0) || (n == 6), (n == 6) ? 8'hFF : 8'h00);
         if (n >= 4 && n <= 11) payload[11-n] = x;
      end
      chk("busy_payload", payload, 8'h00);
      cyc(1'b0, 8'h00);
      chk("busy_no_extra_frame", x_valid, 1'b0);
      run_frame(8'h5A, bits);
      chk("after_busy_frame", bits, exp_bits(8'h5A));
      cyc(1'b0, 8'h00);

      // Reset during payload bit 3, then a clean 0x3C frame
      cyc(1'b1, 8'h55);
      for (int n = 1; n <= 6; n++) cyc(1'b0, 8'h00);
      chk("pre_reset_x_valid", x_valid, 1'b1);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_x", x, 1'b0);
      chk("midrst_x_valid", x_valid, 1'b0);
      chk("midrst_frame_done", frame_done, 1'b0);
      chk("midrst_data_ready", data_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      run_frame(8'h3C, bits);
      chk("post_reset_frame", bits, c3_bits);
      cyc(1'b0, 8'h00);
      chk("post_reset_idle", x_valid, 1'b0);

      // 1101 Mealy detector on x: one hit per 0x00 frame, on the 4th sync bit
      hist   = 3'b000;
      ycount = 0;
      for (int n = 0; n < 3 * FL + 2; n++) begin
         cyc(n <= 2 * FL, 8'h00);
         y = (hist == 3'b110) && x;
         chk("mealy_y", y, (n < 3 * FL) && (n % FL == 3));
         if (y) ycount++;
         hist = {hist[1:0], x};
      end
      chk("mealy_count", ycount, 3);

      // Randomised traffic against the model
      for (int k = 0; k < 400; k++) begin
         cyc($urandom_range(0, 3) != 0, 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
